// File: rtl/pll_reset_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pll_ctrl_pkg
//   Shared definitions for the PLL reset supervisor:
//     state_t    - supervisor state, 3-bit encoding
//     max3       - largest of three counts
//     cnt_width  - width of the shared phase counter (never below 1 bit)
// ---------------------------------------------------------------------------
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // The counter only ever has to reach (largest count - 1), so $clog2 of the
  // largest count is enough.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = max3(a, b, c);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_reset_ctrl_sync_bit.sv
// ---------------------------------------------------------------------------
// sync_bit
//   Multi-flop synchroniser for a single asynchronous level.
//   Ports:
//     refclk  in   destination clock
//     rst_n   in   asynchronous active-low clear (all stages to 0)
//     d       in   asynchronous input level
//     q       out  d after STAGES refclk flops
// ---------------------------------------------------------------------------
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic refclk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// ---------------------------------------------------------------------------
// pll_reset_ctrl
//   PLL start-up supervisor on the board reference clock. Pulses the PLL
//   reset, waits for lock, requires lock to stay stable before releasing the
//   core reset, retries on lock timeout and raises a sticky fault after
//   RETRY_LIMIT failed attempts.
//   Ports:
//     refclk     in   50 MHz reference clock (same clock that feeds the PLL)
//     rst_n      in   asynchronous active-low reset
//     soft_rst   in   synchronous re-initialise request (level)
//     pll_locked in   raw PLL lock indication, asynchronous
//     pll_rst    out  active-high reset to the PLL
//     sys_reset  out  active-high reset to core logic
//     ready      out  high in RUN only
//     fault      out  high in FAULT only
//     retry_cnt  out  failed attempts since last success or soft_rst
// ---------------------------------------------------------------------------
module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int RETRY_LIMIT    = 3,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                             refclk,
  input  logic                             rst_n,
  input  logic                             soft_rst,
  input  logic                             pll_locked,
  output logic                             pll_rst,
  output logic                             sys_reset,
  output logic                             ready,
  output logic                             fault,
  output logic [$clog2(RETRY_LIMIT+1)-1:0] retry_cnt
);

  localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int RC_W  = $clog2(RETRY_LIMIT + 1);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RC_W-1:0]  RETRY_MAX   = RC_W'(RETRY_LIMIT);

  logic locked_s;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              cnt_advance;
  logic [RC_W-1:0]   retry_reg, retry_next;
  logic [RC_W-1:0]   retry_inc;
  logic              pll_rst_reg, pll_rst_next;
  logic              sys_reset_reg, sys_reset_next;
  logic              ready_reg, ready_next;
  logic              fault_reg, fault_next;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .refclk (refclk),
    .rst_n  (rst_n),
    .d      (pll_locked),
    .q      (locked_s)
  );

  assign retry_inc = retry_reg + RC_W'(1);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= PLL_RST;
      cnt_reg       <= '0;
      retry_reg     <= '0;
      pll_rst_reg   <= 1'b1;
      sys_reset_reg <= 1'b1;
      ready_reg     <= 1'b0;
      fault_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      retry_reg     <= retry_next;
      pll_rst_reg   <= pll_rst_next;
      sys_reset_reg <= sys_reset_next;
      ready_reg     <= ready_next;
      fault_reg     <= fault_next;
    end
  end

  // Next state. The counter only advances while a state is held and still
  // short of its terminal value; every exit (and every soft_rst cycle)
  // clears it, so it can never wrap.
  always_comb begin
    state_next  = state_reg;
    retry_next  = retry_reg;
    cnt_advance = 1'b0;

    if (soft_rst) begin
      state_next = PLL_RST;
      retry_next = '0;
    end else begin
      case (state_reg)
        PLL_RST: begin
          if (cnt_reg == RST_LAST) state_next = WAIT_LOCK;
          else                     cnt_advance = 1'b1;
        end
        WAIT_LOCK: begin
          // Lock beats a coincident timeout.
          if (locked_s) begin
            state_next = STABLE;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            retry_next = retry_inc;
            state_next = (retry_inc == RETRY_MAX) ? FAULT : PLL_RST;
          end else begin
            cnt_advance = 1'b1;
          end
        end
        STABLE: begin
          // A drop restarts the lock wait without counting a failed attempt.
          if (!locked_s) begin
            state_next = WAIT_LOCK;
          end else if (cnt_reg == STABLE_LAST) begin
            state_next = RUN;
            retry_next = '0;
          end else begin
            cnt_advance = 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) state_next = PLL_RST;
        end
        FAULT: begin
          state_next = FAULT;
        end
        default: begin
          state_next = PLL_RST;
        end
      endcase
    end

    cnt_next = cnt_advance ? (cnt_reg + CNT_W'(1)) : '0;
  end

  // Outputs are decoded from the next state and registered, so they change
  // on the same edge as the state itself.
  always_comb begin
    pll_rst_next   = (state_next == PLL_RST) || (state_next == FAULT);
    sys_reset_next = (state_next != RUN);
    ready_next     = (state_next == RUN);
    fault_next     = (state_next == FAULT);
  end

  assign pll_rst   = pll_rst_reg;
  assign sys_reset = sys_reset_reg;
  assign ready     = ready_reg;
  assign fault     = fault_reg;
  assign retry_cnt = retry_reg;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_ctrl
//   Self-checking bench for pll_reset_ctrl with small parameters.
//   Cycle n is the interval after the n-th refclk edge following reset
//   release; an input applied "for cycle n" is driven before edge n.
//   Output vectors are {pll_rst, sys_reset, ready, fault, retry_cnt[1:0]}.
// ---------------------------------------------------------------------------
module tb_pll_reset_ctrl;

  localparam int PRC = 4;
  localparam int LT  = 20;
  localparam int SC  = 8;
  localparam int RL  = 2;
  localparam int SS  = 2;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       soft_rst = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst, sys_reset, ready, fault;
  logic [1:0] retry_cnt;
  logic [5:0] dut_outs;

  always #5 refclk = ~refclk;

  pll_reset_ctrl #(
    .PLL_RST_CYCLES (PRC),
    .LOCK_TIMEOUT   (LT),
    .STABLE_CYCLES  (SC),
    .RETRY_LIMIT    (RL),
    .SYNC_STAGES    (SS)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .soft_rst   (soft_rst),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_reset  (sys_reset),
    .ready      (ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt)
  );

  assign dut_outs = {pll_rst, sys_reset, ready, fault, retry_cnt};

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // -------------------------------------------------------------------------
  // Reference model: a named phase plus the edge at which it began. A phase
  // ends once it has lasted its full duration; lock is seen SS edges late.
  // -------------------------------------------------------------------------
  string m_phase;
  int    m_now, m_start, m_retries;
  bit    m_lock_q[$];

  task automatic model_reset();
    m_phase   = "pulse";
    m_now     = 0;
    m_start   = 0;
    m_retries = 0;
    m_lock_q.delete();
    for (int i = 0; i < SS; i++) m_lock_q.push_back(1'b0);
  endtask

  task automatic enter(input string p);
    m_phase = p;
    m_start = m_now;
  endtask

  task automatic model_step(input bit s, input bit raw);
    bit ls;
    int lasted;
    m_now++;
    ls = m_lock_q.pop_front();
    m_lock_q.push_back(raw);
    lasted = m_now - m_start;
    if (s) begin
      enter("pulse");
      m_retries = 0;
    end else if (m_phase == "pulse") begin
      if (lasted == PRC) enter("wait");
    end else if (m_phase == "wait") begin
      if (ls) enter("settle");
      else if (lasted == LT) begin
        m_retries++;
        if (m_retries == RL) enter("fault");
        else                 enter("pulse");
      end
    end else if (m_phase == "settle") begin
      if (!ls) enter("wait");
      else if (lasted == SC) begin
        enter("run");
        m_retries = 0;
      end
    end else if (m_phase == "run") begin
      if (!ls) enter("pulse");
    end
  endtask

  function automatic logic [5:0] model_outs();
    logic [1:0] rc;
    rc = 2'(m_retries);
    return {(m_phase == "pulse") || (m_phase == "fault"), m_phase != "run",
            m_phase == "run", m_phase == "fault", rc};
  endfunction

  task automatic tick(input bit s, input bit l);
    soft_rst   = s;
    pll_locked = l;
    @(posedge refclk);
    model_step(s, l);
    #1;
    check($sformatf("model@%0d", m_now), dut_outs, model_outs());
  endtask

  task automatic do_reset();
    @(posedge refclk);
    #3 rst_n = 1'b0;
    soft_rst   = 1'b0;
    pll_locked = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit         lock;
    int         n;
    logic [5:0] exp;
    string      name;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  int bad;
  int seg;
  bit lk;

  initial begin
    // Clean start, lock loss in RUN, then a single timeout and recovery.
    vecs[0]  = '{1'b0, 3,  6'b110000, "boot_pulse_c3"};
    vecs[1]  = '{1'b0, 1,  6'b010000, "boot_pulse_end_c4"};
    vecs[2]  = '{1'b0, 5,  6'b010000, "wait_c9"};
    vecs[3]  = '{1'b1, 10, 6'b010000, "stable_c19"};
    vecs[4]  = '{1'b1, 1,  6'b001000, "run_c20"};
    vecs[5]  = '{1'b0, 2,  6'b001000, "run_hold_c22"};
    vecs[6]  = '{1'b0, 1,  6'b110000, "lockloss_c23"};
    vecs[7]  = '{1'b0, 3,  6'b110000, "repulse_c26"};
    vecs[8]  = '{1'b0, 1,  6'b010000, "repulse_end_c27"};
    vecs[9]  = '{1'b0, 19, 6'b010000, "wait_c46"};
    vecs[10] = '{1'b0, 1,  6'b110001, "timeout_c47"};
    vecs[11] = '{1'b1, 4,  6'b010001, "retry_wait_c51"};
    vecs[12] = '{1'b1, 8,  6'b010001, "retry_stable_c59"};
    vecs[13] = '{1'b1, 1,  6'b001000, "retry_run_c60"};

    repeat (2) @(posedge refclk);
    #3 rst_n = 1'b1;
    model_reset();
    #1 check("reset_state", dut_outs, 6'b110000);

    for (int i = 0; i < NV; i++) begin
      repeat (vecs[i].n) tick(1'b0, vecs[i].lock);
      check(vecs[i].name, dut_outs, vecs[i].exp);
    end

    // Fault after two timeouts, held for 100 cycles.
    do_reset();
    repeat (47) tick(1'b0, 1'b0);
    check("fault_pre_c47", dut_outs, 6'b010001);
    tick(1'b0, 1'b0);
    check("fault_entry_c48", dut_outs, 6'b110110);
    bad = 0;
    repeat (100) begin
      tick(1'b0, 1'b0);
      if (dut_outs !== 6'b110110) bad++;
    end
    check_int("fault_hold_bad_cycles", bad, 0);

    // soft_rst pulse in FAULT.
    tick(1'b1, 1'b0);
    check("soft_in_fault", dut_outs, 6'b110000);
    repeat (3) tick(1'b0, 1'b0);
    check("soft_pulse_last", dut_outs, 6'b110000);
    tick(1'b0, 1'b0);
    check("soft_pulse_end", dut_outs, 6'b010000);

    // Instability: 5 high, 1 low, then high; RUN needs a fresh full window.
    repeat (5) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    repeat (10) tick(1'b0, 1'b1);
    check("instab_not_yet", dut_outs, 6'b010000);
    tick(1'b0, 1'b1);
    check("instab_run", dut_outs, 6'b001000);

    // soft_rst in RUN, then a timeout coinciding with synchronised lock.
    tick(1'b1, 1'b1);
    check("soft_in_run", dut_outs, 6'b110000);
    repeat (3) tick(1'b0, 1'b0);
    check("run_soft_pulse_last", dut_outs, 6'b110000);
    repeat (18) tick(1'b0, 1'b0);
    check("tie_pre", dut_outs, 6'b010000);
    repeat (3) tick(1'b0, 1'b1);
    check("tie_lock_wins", dut_outs, 6'b010000);
    repeat (7) tick(1'b0, 1'b1);
    check("tie_stable_last", dut_outs, 6'b010000);
    tick(1'b0, 1'b1);
    check("tie_run", dut_outs, 6'b001000);

    // Lock loss and soft_rst land on the same synchronised cycle.
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("loss_soft_pre", dut_outs, 6'b001000);
    tick(1'b1, 1'b0);
    check("loss_and_soft", dut_outs, 6'b110000);

    // rst_n asserted mid-STABLE takes effect before the next edge.
    repeat (7) tick(1'b0, 1'b1);
    check("async_pre_stable", dut_outs, 6'b010000);
    rst_n = 1'b0;
    #1 check("async_reset", dut_outs, 6'b110000);
    #2 rst_n = 1'b1;
    model_reset();

    // Randomised lock behaviour with occasional soft_rst.
    seg = 0;
    lk  = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (seg == 0) begin
        lk  = ($urandom_range(0, 3) != 0);
        seg = $urandom_range(1, 40);
      end
      seg--;
      tick($urandom_range(0, 99) == 0, lk);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
